// File: rtl/cache_pkg.sv
// Shared types, widths and helpers for the data-cache miss controller.
// Defaults describe a 1 KiB direct-mapped cache with one-word lines.
package cache_pkg;

  localparam int ADDR_W = 32;
  localparam int DEF_CACHE_SIZE = 1024;
  localparam int DEF_LINE_SIZE = 4;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOOKUP,
    S_WB_REQ,
    S_WB_WAIT,
    S_RF_REQ,
    S_RF_WAIT
  } cache_state_e;

  // Number of index bits for a given geometry
  function automatic int idx_width(input int csize, input int lsize);
    return $clog2(csize / lsize);
  endfunction

  // Number of tag bits for a given geometry
  function automatic int tag_width(input int csize, input int lsize);
    return ADDR_W - $clog2(csize / lsize) - $clog2(lsize);
  endfunction

  // Byte i comes from wdata where wstrb[i] is set, else from base
  function automatic logic [31:0] merge_bytes(
    input logic [31:0] base,
    input logic [31:0] wdata,
    input logic [3:0]  wstrb
  );
    logic [31:0] r;
    r = base;
    for (int i = 0; i < 4; i++) begin
      if (wstrb[i]) r[8*i +: 8] = wdata[8*i +: 8];
    end
    return r;
  endfunction

endpackage

// File: rtl/cache_ctrl.sv
// Miss handler for the direct-mapped write-back, write-allocate D-cache.
// One access in flight; dirty victims are written back before refill.
module cache_ctrl
  import cache_pkg::*;
#(
  parameter int CACHE_SIZE = DEF_CACHE_SIZE,
  parameter int LINE_SIZE  = DEF_LINE_SIZE,
  parameter int TAG_WIDTH  = tag_width(CACHE_SIZE, LINE_SIZE)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 cpu_req_valid,
  output logic                 cpu_req_ready,
  input  logic [31:0]          cpu_addr,
  input  logic                 cpu_we,
  input  logic [31:0]          cpu_wdata,
  input  logic [3:0]           cpu_wstrb,
  output logic                 cpu_resp_valid,
  output logic [31:0]          cpu_rdata,
  output logic [31:0]          arr_addr,
  input  logic                 arr_hit,
  input  logic                 arr_dirty,
  input  logic [31:0]          arr_data,
  input  logic [TAG_WIDTH-1:0] arr_victim_tag,
  output logic [31:0]          arr_write_data,
  output logic                 arr_write_valid,
  output logic                 arr_write_access,
  output logic                 mem_req_valid,
  input  logic                 mem_req_ready,
  output logic                 mem_we,
  output logic [31:0]          mem_addr,
  output logic [31:0]          mem_wdata,
  input  logic                 mem_resp_valid,
  input  logic [31:0]          mem_rdata
);

  localparam int IDX_W = idx_width(CACHE_SIZE, LINE_SIZE);

  if (LINE_SIZE != 4) begin : g_bad_line
    $error("cache_ctrl: only LINE_SIZE = 4 is supported");
  end

  cache_state_e state_q, state_d;
  logic [31:0]  addr_q, addr_d;
  logic         we_q, we_d;
  logic [31:0]  wdata_q, wdata_d;
  logic [3:0]   wstrb_q, wstrb_d;
  logic [31:0]  vaddr_q, vaddr_d;
  logic [31:0]  vdata_q, vdata_d;

  // State and latched request/victim registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      we_q    <= 1'b0;
      wdata_q <= '0;
      wstrb_q <= '0;
      vaddr_q <= '0;
      vdata_q <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      we_q    <= we_d;
      wdata_q <= wdata_d;
      wstrb_q <= wstrb_d;
      vaddr_q <= vaddr_d;
      vdata_q <= vdata_d;
    end
  end

  // Next-state, latch updates and all outputs
  always_comb begin
    state_d          = state_q;
    addr_d           = addr_q;
    we_d             = we_q;
    wdata_d          = wdata_q;
    wstrb_d          = wstrb_q;
    vaddr_d          = vaddr_q;
    vdata_d          = vdata_q;
    cpu_req_ready    = 1'b0;
    cpu_resp_valid   = 1'b0;
    cpu_rdata        = '0;
    arr_addr         = addr_q;
    arr_write_data   = '0;
    arr_write_valid  = 1'b0;
    arr_write_access = 1'b0;
    mem_req_valid    = 1'b0;
    mem_we           = 1'b0;
    mem_addr         = '0;
    mem_wdata        = '0;
    unique case (state_q)
      S_IDLE: begin
        cpu_req_ready = 1'b1;
        arr_addr      = cpu_addr;
        if (cpu_req_valid) begin
          addr_d  = cpu_addr;
          we_d    = cpu_we;
          wdata_d = cpu_wdata;
          wstrb_d = cpu_wstrb;
          state_d = S_LOOKUP;
        end
      end
      S_LOOKUP: begin
        if (arr_hit) begin
          cpu_resp_valid = 1'b1;
          state_d        = S_IDLE;
          if (we_q) begin
            arr_write_data   = merge_bytes(arr_data, wdata_q, wstrb_q);
            arr_write_valid  = 1'b1;
            arr_write_access = 1'b1;
          end else begin
            cpu_rdata = arr_data;
          end
        end else if (arr_dirty) begin
          vaddr_d = {arr_victim_tag, addr_q[IDX_W+1:2], 2'b00};
          vdata_d = arr_data;
          state_d = S_WB_REQ;
        end else begin
          state_d = S_RF_REQ;
        end
      end
      S_WB_REQ: begin
        mem_req_valid = 1'b1;
        mem_we        = 1'b1;
        mem_addr      = vaddr_q;
        mem_wdata     = vdata_q;
        if (mem_req_ready) state_d = S_WB_WAIT;
      end
      S_WB_WAIT: begin
        if (mem_resp_valid) state_d = S_RF_REQ;
      end
      S_RF_REQ: begin
        mem_req_valid = 1'b1;
        mem_addr      = {addr_q[31:2], 2'b00};
        if (mem_req_ready) state_d = S_RF_WAIT;
      end
      S_RF_WAIT: begin
        if (mem_resp_valid) begin
          arr_write_valid  = 1'b1;
          arr_write_access = we_q;
          arr_write_data   = we_q ? merge_bytes(mem_rdata, wdata_q, wstrb_q)
                                  : mem_rdata;
          cpu_resp_valid   = 1'b1;
          cpu_rdata        = mem_rdata;
          state_d          = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

endmodule
